// File: rtl/afifo_ctrl_pkg.sv
// Shared types and helpers for the AFIFO push/pop controllers.
package afifo_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

    localparam int OVR_CNT_W = 8;

    // Index width for a requester set; never narrower than one bit.
    function automatic int clog2_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/afifo_push_arbiter_rr_pick.sv
// Combinational round-robin select: first valid index at or after ptr, wrapping.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    logic [W-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = W'((int'(ptr) + k) % N);
            if (!found && valid[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/afifo_push_arbiter.sv
// Push-side controller for one AFIFO_18K_BLK: round-robin burst arbitration and flush sequencing.
// Optional overrun event counter enabled by AFIFO_PUSH_ARB_OVR_CNT_EN.
module afifo_push_arbiter
    import afifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 18,
    parameter int BURST_MAX    = 8,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                           clock0,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             in_valid,
    input  logic [NUM_REQ-1:0]             in_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  in_data,
    output logic [NUM_REQ-1:0]             in_ready,
    input  logic                           flush_req,
    output logic                           flush_busy,
    input  logic                           Full,
    input  logic                           Almost_Full,
    input  logic                           Overrun_Error,
    output logic [DATA_WIDTH-1:0]          DIN,
    output logic                           PUSH,
    output logic                           Async_Flush,
    output logic [clog2_w(NUM_REQ)-1:0]    grant_id,
    output logic [OVR_CNT_W-1:0]           overrun_cnt,
    output logic [1:0]                     dbg_state
);

    localparam int GW = clog2_w(NUM_REQ);

    arb_state_t    state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] rr_next;
    logic [7:0]    beat_cnt;
    logic [3:0]    flush_cnt;
    logic          pick_found;
    logic [GW-1:0] pick_idx;
    logic          accept;
    logic          burst_end;

    rr_pick #(.N(NUM_REQ), .W(GW)) u_rr_pick (
        .valid (in_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Hold back when the FIFO is full, or when the push already in flight takes the last slot.
    always_comb begin
        in_ready = '0;
        if (state == GRANT)
            in_ready[grant_id] = !Full && !(PUSH && Almost_Full);
    end

    assign accept    = in_valid[grant_id] && in_ready[grant_id];
    assign burst_end = accept && (in_last[grant_id] || (beat_cnt == 8'(BURST_MAX - 1)));
    assign rr_next   = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;

    // Any flush_req outside FLUSH enters FLUSH on the next edge, so the pending window is that edge.
    assign flush_busy = (state == FLUSH);
    assign dbg_state  = state;

    always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            grant_id    <= '0;
            DIN         <= '0;
            PUSH        <= 1'b0;
            Async_Flush <= 1'b0;
        end else begin
            PUSH <= accept;
            if (accept)
                DIN <= in_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state       <= FLUSH;
                        Async_Flush <= 1'b1;
                        flush_cnt   <= '0;
                    end else if (pick_found) begin
                        grant_id <= pick_idx;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (flush_req) begin
                        state       <= FLUSH;
                        Async_Flush <= 1'b1;
                        flush_cnt   <= '0;
                        rr_ptr      <= rr_next;
                        beat_cnt    <= '0;
                    end else if (burst_end) begin
                        rr_ptr   <= rr_next;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 4'(FLUSH_CYCLES - 1)) begin
                        Async_Flush <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AFIFO_PUSH_ARB_OVR_CNT_EN
    logic ovr_d;

    always_ff @(posedge clock0 or negedge reset_n) begin
        if (!reset_n) begin
            ovr_d       <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            ovr_d <= Overrun_Error;
            if (Async_Flush)
                overrun_cnt <= '0;
            else if (Overrun_Error && !ovr_d && (overrun_cnt != '1))
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end
`else
    logic ovr_unused;
    assign ovr_unused  = Overrun_Error;
    assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_afifo_push_arbiter.sv
// Directed bench for afifo_push_arbiter: vector tables plus hand-written multi-cycle sequences.
module tb_afifo_push_arbiter;
    import afifo_ctrl_pkg::*;

    logic        clock0 = 1'b0;
    logic        reset_n;
    logic [3:0]  in_valid;
    logic [3:0]  in_last;
    logic [71:0] in_data;
    logic [3:0]  in_ready;
    logic        flush_req;
    logic        flush_busy;
    logic        Full;
    logic        Almost_Full;
    logic        Overrun_Error;
    logic [17:0] DIN;
    logic        PUSH;
    logic        Async_Flush;
    logic [1:0]  grant_id;
    logic [7:0]  overrun_cnt;
    logic [1:0]  dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [17:0] exp_q[$];

`ifdef AFIFO_PUSH_ARB_OVR_CNT_EN
    localparam logic [7:0] OVR_EXP3 = 8'd3;
    localparam logic [7:0] OVR_EXPS = 8'd255;
`else
    localparam logic [7:0] OVR_EXP3 = 8'd0;
    localparam logic [7:0] OVR_EXPS = 8'd0;
`endif

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [17:0] base;
        logic        full;
        logic        af;
        logic        freq;
        logic [3:0]  e_ready;
        logic        e_push;
        logic [17:0] e_din;
        logic [1:0]  e_grant;
        logic        e_aflush;
        logic        e_busy;
        logic [1:0]  e_state;
    } vec_t;

    vec_t tab[$];

    afifo_push_arbiter #(
        .NUM_REQ(4), .DATA_WIDTH(18), .BURST_MAX(8), .FLUSH_CYCLES(4)
    ) dut (
        .clock0        (clock0),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_last       (in_last),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .flush_req     (flush_req),
        .flush_busy    (flush_busy),
        .Full          (Full),
        .Almost_Full   (Almost_Full),
        .Overrun_Error (Overrun_Error),
        .DIN           (DIN),
        .PUSH          (PUSH),
        .Async_Flush   (Async_Flush),
        .grant_id      (grant_id),
        .overrun_cnt   (overrun_cnt),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    always #5 clock0 = ~clock0;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // Requester i sees base with its own index in bits [17:16].
    function automatic logic [71:0] pack(input logic [17:0] b);
        logic [71:0] r;
        logic [17:0] s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = b;
            s[17:16] = 2'(i);
            r[i*18 +: 18] = s;
        end
        return r;
    endfunction

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [17:0] b,
                                input logic f, input logic a, input logic fr,
                                input logic [3:0] er, input logic ep, input logic [17:0] ed,
                                input logic [1:0] eg, input logic eaf, input logic eb,
                                input logic [1:0] es);
        vec_t t;
        t.valid = v; t.last = l; t.base = b; t.full = f; t.af = a; t.freq = fr;
        t.e_ready = er; t.e_push = ep; t.e_din = ed; t.e_grant = eg;
        t.e_aflush = eaf; t.e_busy = eb; t.e_state = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic do_reset();
        reset_n = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0; flush_req = 1'b0;
        Full = 1'b0; Almost_Full = 1'b0; Overrun_Error = 1'b0;
        repeat (2) @(negedge clock0);
        reset_n = 1'b1;
    endtask

    task automatic apply(input vec_t t, input string tag, input int row);
        in_valid = t.valid; in_last = t.last; in_data = pack(t.base);
        Full = t.full; Almost_Full = t.af; flush_req = t.freq;
        #1;
        chk($sformatf("%s[%0d].in_ready", tag, row), 32'(in_ready), 32'(t.e_ready));
        chk($sformatf("%s[%0d].push", tag, row), 32'(PUSH), 32'(t.e_push));
        chk($sformatf("%s[%0d].din", tag, row), 32'(DIN), 32'(t.e_din));
        chk($sformatf("%s[%0d].grant", tag, row), 32'(grant_id), 32'(t.e_grant));
        chk($sformatf("%s[%0d].aflush", tag, row), 32'(Async_Flush), 32'(t.e_aflush));
        chk($sformatf("%s[%0d].busy", tag, row), 32'(flush_busy), 32'(t.e_busy));
        chk($sformatf("%s[%0d].state", tag, row), 32'(dbg_state), 32'(t.e_state));
        @(negedge clock0);
    endtask

    task automatic run_tab(input string tag);
        for (int i = 0; i < tab.size(); i++)
            apply(tab[i], tag, i);
    endtask

    task automatic ovr_pulse();
        Overrun_Error = 1'b1;
        @(negedge clock0);
        Overrun_Error = 1'b0;
        @(negedge clock0);
    endtask

    initial begin
        logic exp_push;

        // reset values
        reset_n = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0; flush_req = 1'b0;
        Full = 1'b0; Almost_Full = 1'b0; Overrun_Error = 1'b0;
        #2;
        chk("rst.in_ready", 32'(in_ready), 32'h0);
        chk("rst.push", 32'(PUSH), 32'h0);
        chk("rst.din", 32'(DIN), 32'h0);
        chk("rst.aflush", 32'(Async_Flush), 32'h0);
        chk("rst.busy", 32'(flush_busy), 32'h0);
        chk("rst.grant", 32'(grant_id), 32'h0);
        chk("rst.ovr", 32'(overrun_cnt), 32'h0);
        chk("rst.state", 32'(dbg_state), 32'(IDLE));
        do_reset();

        // req0 three-beat burst
        tab.delete();
        tab.push_back(mk(4'b0001, 4'b0000, 18'hA, 0, 0, 0, 4'b0000, 0, 18'h0, 2'd0, 0, 0, IDLE));
        tab.push_back(mk(4'b0001, 4'b0000, 18'hA, 0, 0, 0, 4'b0001, 0, 18'h0, 2'd0, 0, 0, GRANT));
        tab.push_back(mk(4'b0001, 4'b0000, 18'hB, 0, 0, 0, 4'b0001, 1, 18'hA, 2'd0, 0, 0, GRANT));
        tab.push_back(mk(4'b0001, 4'b0001, 18'hC, 0, 0, 0, 4'b0001, 1, 18'hB, 2'd0, 0, 0, GRANT));
        tab.push_back(mk(4'b0000, 4'b0000, 18'h0, 0, 0, 0, 4'b0000, 1, 18'hC, 2'd0, 0, 0, IDLE));
        tab.push_back(mk(4'b0000, 4'b0000, 18'h0, 0, 0, 0, 4'b0000, 0, 18'hC, 2'd0, 0, 0, IDLE));
        run_tab("burst3");

        // all requesters streaming: 9-cycle period, 8 pushes per grant, rotation 0,1,2,3,0
        do_reset();
        exp_q.delete();
        in_valid = 4'hF; in_last = 4'h0;
        for (int c = 0; c < 46; c++) begin
            in_data = pack(18'(c));
            if (c >= 1 && ((c - 1) % 9) < 8)
                exp_q.push_back({2'(((c - 1) / 9) % 4), 16'(c)});
            #1;
            exp_push = (c >= 2) && (((c - 2) % 9) < 8);
            chk($sformatf("rot[%0d].push", c), 32'(PUSH), 32'(exp_push));
            if (PUSH && exp_push) begin
                if (exp_q.size() == 0)
                    chk($sformatf("rot[%0d].q_empty", c), 32'(1), 32'(0));
                else
                    chk($sformatf("rot[%0d].din", c), 32'(DIN), 32'(exp_q.pop_front()));
                chk($sformatf("rot[%0d].grant", c), 32'(grant_id), 32'(((c - 2) / 9) % 4));
            end
            @(negedge clock0);
        end
        chk("rot.q_left", 32'(exp_q.size()), 32'(0));

        // Almost_Full with in-flight push, then Full stall
        do_reset();
        tab.delete();
        tab.push_back(mk(4'b0010, 4'b0000, 18'h11, 0, 0, 0, 4'b0000, 0, 18'h0,     2'd0, 0, 0, IDLE));
        tab.push_back(mk(4'b0010, 4'b0000, 18'h11, 0, 0, 0, 4'b0010, 0, 18'h0,     2'd1, 0, 0, GRANT));
        tab.push_back(mk(4'b0010, 4'b0000, 18'h12, 0, 1, 0, 4'b0000, 1, 18'h10011, 2'd1, 0, 0, GRANT));
        tab.push_back(mk(4'b0010, 4'b0000, 18'h13, 1, 1, 0, 4'b0000, 0, 18'h10011, 2'd1, 0, 0, GRANT));
        tab.push_back(mk(4'b0010, 4'b0000, 18'h14, 1, 1, 0, 4'b0000, 0, 18'h10011, 2'd1, 0, 0, GRANT));
        tab.push_back(mk(4'b0010, 4'b0000, 18'h22, 0, 1, 0, 4'b0010, 0, 18'h10011, 2'd1, 0, 0, GRANT));
        tab.push_back(mk(4'b0010, 4'b0000, 18'h33, 0, 0, 0, 4'b0010, 1, 18'h10022, 2'd1, 0, 0, GRANT));
        tab.push_back(mk(4'b0000, 4'b0000, 18'h44, 0, 0, 0, 4'b0010, 1, 18'h10033, 2'd1, 0, 0, GRANT));
        tab.push_back(mk(4'b0000, 4'b0000, 18'h44, 0, 0, 0, 4'b0010, 0, 18'h10033, 2'd1, 0, 0, GRANT));
        run_tab("full");

        // flush preempting the 2nd beat of a req2 burst; next grant to req3
        do_reset();
        tab.delete();
        tab.push_back(mk(4'b1100, 4'b0000, 18'h40, 0, 0, 0, 4'b0000, 0, 18'h0,     2'd0, 0, 0, IDLE));
        tab.push_back(mk(4'b1100, 4'b0000, 18'h41, 0, 0, 0, 4'b0100, 0, 18'h0,     2'd2, 0, 0, GRANT));
        tab.push_back(mk(4'b1100, 4'b0000, 18'h42, 0, 0, 1, 4'b0100, 1, 18'h20041, 2'd2, 0, 0, GRANT));
        tab.push_back(mk(4'b1100, 4'b0000, 18'h43, 0, 0, 0, 4'b0000, 1, 18'h20042, 2'd2, 1, 1, FLUSH));
        tab.push_back(mk(4'b1100, 4'b0000, 18'h43, 0, 0, 1, 4'b0000, 0, 18'h20042, 2'd2, 1, 1, FLUSH));
        tab.push_back(mk(4'b1100, 4'b0000, 18'h43, 0, 0, 0, 4'b0000, 0, 18'h20042, 2'd2, 1, 1, FLUSH));
        tab.push_back(mk(4'b1100, 4'b0000, 18'h43, 0, 0, 0, 4'b0000, 0, 18'h20042, 2'd2, 1, 1, FLUSH));
        tab.push_back(mk(4'b1100, 4'b0000, 18'h43, 0, 0, 0, 4'b0000, 0, 18'h20042, 2'd2, 0, 0, IDLE));
        tab.push_back(mk(4'b1100, 4'b0000, 18'h43, 0, 0, 0, 4'b1000, 0, 18'h20042, 2'd3, 0, 0, GRANT));
        tab.push_back(mk(4'b0000, 4'b0000, 18'h44, 0, 0, 0, 4'b1000, 1, 18'h30043, 2'd3, 0, 0, GRANT));
        run_tab("flush");

        // asynchronous reset in the middle of a req2 burst
        do_reset();
        tab.delete();
        tab.push_back(mk(4'b0100, 4'b0000, 18'h50, 0, 0, 0, 4'b0000, 0, 18'h0,     2'd0, 0, 0, IDLE));
        tab.push_back(mk(4'b0100, 4'b0000, 18'h51, 0, 0, 0, 4'b0100, 0, 18'h0,     2'd2, 0, 0, GRANT));
        tab.push_back(mk(4'b0100, 4'b0000, 18'h52, 0, 0, 0, 4'b0100, 1, 18'h20051, 2'd2, 0, 0, GRANT));
        run_tab("pre_rst");
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst.push", 32'(PUSH), 32'h0);
        chk("mid_rst.aflush", 32'(Async_Flush), 32'h0);
        chk("mid_rst.in_ready", 32'(in_ready), 32'h0);
        chk("mid_rst.grant", 32'(grant_id), 32'h0);
        chk("mid_rst.din", 32'(DIN), 32'h0);
        chk("mid_rst.state", 32'(dbg_state), 32'(IDLE));
        @(negedge clock0);
        reset_n = 1'b1;
        tab.delete();
        tab.push_back(mk(4'b1111, 4'b0000, 18'h60, 0, 0, 0, 4'b0000, 0, 18'h0, 2'd0, 0, 0, IDLE));
        tab.push_back(mk(4'b1111, 4'b0000, 18'h61, 0, 0, 0, 4'b0001, 0, 18'h0, 2'd0, 0, 0, GRANT));
        tab.push_back(mk(4'b0000, 4'b0000, 18'h62, 0, 0, 0, 4'b0001, 1, 18'h61, 2'd0, 0, 0, GRANT));
        run_tab("post_rst");

        // overrun counter: 3 pulses, flush clear, saturation
        do_reset();
        repeat (3) ovr_pulse();
        @(negedge clock0);
        chk("ovr.three", 32'(overrun_cnt), 32'(OVR_EXP3));
        flush_req = 1'b1;
        @(negedge clock0);
        flush_req = 1'b0;
        repeat (6) @(negedge clock0);
        chk("ovr.after_flush", 32'(overrun_cnt), 32'h0);
        repeat (300) ovr_pulse();
        @(negedge clock0);
        chk("ovr.saturate", 32'(overrun_cnt), 32'(OVR_EXPS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
